// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: f = a - b - b_in (mod 2^WIDTH), LSB first,
// one bit pair per clock, with borrow-out and zero flag.
// Optional compare flags (a_eq_b, a_lt_b) are built when SERIAL_SUB_CMP_EN is defined.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             b_out,
  output logic             zero
`ifdef SERIAL_SUB_CMP_EN
  ,
  output logic             a_eq_b,
  output logic             a_lt_b
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CntW-1:0]  cnt_q;
  logic             brw_q;
  logic             bin_q;

  logic             diff_bit;
  logic             brw_d;

  // One full-subtractor stage on the current LSB pair.
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ brw_q;
    brw_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  end

  // Control FSM with registered outputs; the done cycle is spent back in
  // StIdle, so start is also gated by done to keep it from being accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bin_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f       <= '0;
      b_out   <= 1'b0;
      zero    <= 1'b1;
`ifdef SERIAL_SUB_CMP_EN
      a_eq_b  <= 1'b0;
      a_lt_b  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !done) begin
            a_q     <= a;
            b_q     <= b;
            bin_q   <= b_in;
            brw_q   <= b_in;
            res_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          res_q <= {diff_bit, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          brw_q <= brw_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          f       <= res_q;
          b_out   <= brw_q;
          zero    <= (res_q == '0);
          done    <= 1'b1;
`ifdef SERIAL_SUB_CMP_EN
          a_eq_b  <= !bin_q && (res_q == '0) && !brw_q;
          a_lt_b  <= !bin_q && brw_q;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4); checks results, latency,
// start filtering and mid-operation reset. Compare flags checked when
// SERIAL_SUB_CMP_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] f;
  logic         b_out;
  logic         zero;
`ifdef SERIAL_SUB_CMP_EN
  logic         a_eq_b;
  logic         a_lt_b;
`endif

  int checks = 0;
  int fails  = 0;
  int n;
  int pulses;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .f     (f),
    .b_out (b_out),
    .zero  (zero)
`ifdef SERIAL_SUB_CMP_EN
    ,
    .a_eq_b(a_eq_b),
    .a_lt_b(a_lt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done; n counts edges after the acceptance edge.
  task automatic wait_done();
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic [W-1:0] ef, input logic ebo,
                        input logic ez, input logic eeq, input logic elt);
    @(negedge clk);
    a = ta; b = tb; b_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_accept"}, busy, 1);
    check({tag, "_done_early"}, done, 0);
    n = 0;
    wait_done();
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_f"}, f, ef);
    check({tag, "_b_out"}, b_out, ebo);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_busy_in_done"}, busy, 1);
`ifdef SERIAL_SUB_CMP_EN
    check({tag, "_a_eq_b"}, a_eq_b, eeq);
    check({tag, "_a_lt_b"}, a_lt_b, elt);
`else
    if (eeq && elt) $display("note: %s flag expectations unused", tag);
`endif
    @(posedge clk); #1;
    check({tag, "_done_pulse_width"}, done, 0);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_f", f, 0);
    check("rst_b_out", b_out, 0);
    check("rst_zero", zero, 1);
`ifdef SERIAL_SUB_CMP_EN
    check("rst_a_eq_b", a_eq_b, 0);
    check("rst_a_lt_b", a_lt_b, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_busy", busy, 0);

    // Basic vectors
    run_op("7m3", 4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("3m7", 4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("0m0b1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("5m5", 4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("0m15", 4'd0, 4'd15, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("15m0b1", 4'd15, 4'd0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Outputs hold in IDLE while inputs wiggle
    a = 4'd9; b = 4'd1; b_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_f", f, 4'hE);
    check("hold_busy", busy, 0);

    // Start ignored during SHIFT and during the done cycle
    @(negedge clk);
    a = 4'd7; b = 4'd3; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 4'd1; b = 4'd9; b_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    wait_done();
    check("ign_latency", n, W + 1);
    check("ign_f", f, 4'h4);
    check("ign_b_out", b_out, 0);
    a = 4'd2; b = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_done_fall", done, 0);
    check("ign_busy_after", busy, 0);
    pulses = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("ign_no_second_op", pulses, 0);
    check("ign_f_hold", f, 4'h4);

    // Reset during the second SHIFT cycle aborts the operation
    @(negedge clk);
    a = 4'd6; b = 4'd1; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_f", f, 0);
    check("abort_zero", zero, 1);
    rst_n = 1'b1;
    pulses = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op("9m2", 4'd9, 4'd2, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
